// File: rtl/ysyx_24070017_alu_arbiter_if.sv
// Bus bundle for the two-requester ALU arbiter: request/response channels plus the ALU port.
// The arbiter takes the slave view; the requesters and the ALU together take the master view.
interface ysyx_24070017_alu_arbiter_if #(
  parameter int unsigned WORD_LENGTH = 32
);
  // Packed two-requester buses are {req1, req0}.
  logic [1:0]                  req_valid;
  logic [1:0]                  req_ready;
  logic [1:0][6:0]             req_opcode;
  logic [1:0][2:0]             req_funct3;
  logic [1:0][6:0]             req_funct7;
  logic [1:0][WORD_LENGTH-1:0] req_src1;
  logic [1:0][WORD_LENGTH-1:0] req_src2;

  logic [1:0]                  rsp_valid;
  logic [1:0]                  rsp_ready;
  logic [WORD_LENGTH-1:0]      rsp_result;

  logic [6:0]                  alu_opcode;
  logic [2:0]                  alu_funct3;
  logic [6:0]                  alu_funct7;
  logic [WORD_LENGTH-1:0]      alu_src1;
  logic [WORD_LENGTH-1:0]      alu_src2;
  logic [WORD_LENGTH-1:0]      alu_result;

  modport master (
    output req_valid, req_opcode, req_funct3, req_funct7, req_src1, req_src2,
    input  req_ready,
    input  rsp_valid, rsp_result,
    output rsp_ready,
    input  alu_opcode, alu_funct3, alu_funct7, alu_src1, alu_src2,
    output alu_result
  );

  modport slave (
    input  req_valid, req_opcode, req_funct3, req_funct7, req_src1, req_src2,
    output req_ready,
    output rsp_valid, rsp_result,
    input  rsp_ready,
    output alu_opcode, alu_funct3, alu_funct7, alu_src1, alu_src2,
    input  alu_result
  );
endinterface

// File: rtl/ysyx_24070017_alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the EXU (req 0) and LSU AGU (req 1).
// Operands are registered onto the ALU, the result is captured in EXEC and returned in RESP.
module ysyx_24070017_alu_arbiter #(
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  ysyx_24070017_alu_arbiter_if.slave        bus,
  output logic                              busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   owner_q, owner_d;
  logic [6:0]             alu_opcode_q, alu_opcode_d;
  logic [2:0]             alu_funct3_q, alu_funct3_d;
  logic [6:0]             alu_funct7_q, alu_funct7_d;
  logic [WORD_LENGTH-1:0] alu_src1_q, alu_src1_d;
  logic [WORD_LENGTH-1:0] alu_src2_q, alu_src2_d;
  logic [WORD_LENGTH-1:0] rsp_result_q, rsp_result_d;
  logic [1:0]             rsp_valid_q, rsp_valid_d;

  logic                   grant;
  logic [1:0]             req_ready;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    grant = 1'b0;
    unique case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase
  end

  // Gated by rst so ready drops immediately while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == StIdle && !rst && (bus.req_valid != 2'b00)) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_opcode_d = alu_opcode_q;
    alu_funct3_d = alu_funct3_q;
    alu_funct7_d = alu_funct7_q;
    alu_src1_d   = alu_src1_q;
    alu_src2_d   = alu_src2_q;
    rsp_result_d = rsp_result_q;
    rsp_valid_d  = rsp_valid_q;

    unique case (state_q)
      StIdle: begin
        if (req_ready != 2'b00) begin
          alu_opcode_d = bus.req_opcode[grant];
          alu_funct3_d = bus.req_funct3[grant];
          alu_funct7_d = bus.req_funct7[grant];
          alu_src1_d   = bus.req_src1[grant];
          alu_src2_d   = bus.req_src2[grant];
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = StExec;
        end
      end
      StExec: begin
        rsp_result_d          = bus.alu_result;
        rsp_valid_d           = 2'b00;
        rsp_valid_d[owner_q]  = 1'b1;
        state_d               = StResp;
      end
      StResp: begin
        // Only the owner's ready can retire the response.
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = StIdle;
        end
      end
      default: begin
        rsp_valid_d = 2'b00;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_opcode_q <= '0;
      alu_funct3_q <= '0;
      alu_funct7_q <= '0;
      alu_src1_q   <= '0;
      alu_src2_q   <= '0;
      rsp_result_q <= '0;
      rsp_valid_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_opcode_q <= alu_opcode_d;
      alu_funct3_q <= alu_funct3_d;
      alu_funct7_q <= alu_funct7_d;
      alu_src1_q   <= alu_src1_d;
      alu_src2_q   <= alu_src2_d;
      rsp_result_q <= rsp_result_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_funct3 = alu_funct3_q;
  assign bus.alu_funct7 = alu_funct7_q;
  assign bus.alu_src1   = alu_src1_q;
  assign bus.alu_src2   = alu_src2_q;
  assign busy           = (state_q != StIdle);

endmodule
